// File: rtl/rv64_pkg.sv
`default_nettype none
// ============================================================================
// Package : rv64_pkg
// Purpose : Shared types and encodings for the RV64I integer execute datapath.
//           Holds the ALU operation enum, the major opcodes handled here and
//           the funct3/funct7/funct6 field encodings used by the decoder.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package rv64_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_ADDW  = 4'd10,
    ALU_SUBW  = 4'd11,
    ALU_SLLW  = 4'd12,
    ALU_SRLW  = 4'd13,
    ALU_SRAW  = 4'd14,
    ALU_PASSB = 4'd15
  } alu_op_e;

  // Major opcodes
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;

  // funct3 encodings
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // funct7 encodings (R-type and 32-bit immediate shifts)
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // funct6 encodings (64-bit immediate shifts carry a 6-bit shamt)
  localparam logic [5:0] F6_BASE = 6'b000000;
  localparam logic [5:0] F6_ALT  = 6'b010000;

endpackage
`default_nettype wire

// File: rtl/rv64_int_datapath_if.sv
`default_nettype none
// ============================================================================
// Interface : rv64_int_datapath_if
// Purpose   : Instruction issue / result retire / debug read bundle of the
//             integer execute datapath.
// Signals   : instr_valid, instr        - issue side (master -> slave)
//             result_valid, result,
//             result_rd, illegal        - retire side (slave -> master)
//             dbg_addr / dbg_data       - combinational register peek
// Modports  : master (fetch/control side), slave (datapath)
// Revision  : 1.0 - initial release
// ============================================================================
interface rv64_int_datapath_if;
  logic        instr_valid;
  logic [31:0] instr;
  logic        result_valid;
  logic [63:0] result;
  logic [4:0]  result_rd;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [63:0] dbg_data;

  modport master (
    output instr_valid, instr, dbg_addr,
    input  result_valid, result, result_rd, illegal, dbg_data
  );

  modport slave (
    input  instr_valid, instr, dbg_addr,
    output result_valid, result, result_rd, illegal, dbg_data
  );
endinterface
`default_nettype wire

// File: rtl/rv64_alu.sv
`default_nettype none
// ============================================================================
// Module  : rv64_alu
// Purpose : Combinational RV64I ALU. 64-bit shifts use b[5:0]; W operations
//           work on the low 32 bits (shift by b[4:0]) and sign-extend bit 31.
// Ports   : a, b  in  64  operands
//           op    in   4  ALU operation
//           y     out 64  result
// Revision: 1.0 - initial release
// ============================================================================
module rv64_alu
  import rv64_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  alu_op_e     op,
  output logic [63:0] y
);

  logic [31:0] w;

  always_comb begin
    y = '0;
    w = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[5:0];
      ALU_SLT:  y = {63'b0, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {63'b0, (a < b)};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[5:0];
      ALU_SRA:  y = $signed(a) >>> b[5:0];
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      ALU_ADDW: begin
        w = a[31:0] + b[31:0];
        y = {{32{w[31]}}, w};
      end
      ALU_SUBW: begin
        w = a[31:0] - b[31:0];
        y = {{32{w[31]}}, w};
      end
      ALU_SLLW: begin
        w = a[31:0] << b[4:0];
        y = {{32{w[31]}}, w};
      end
      ALU_SRLW: begin
        w = a[31:0] >> b[4:0];
        y = {{32{w[31]}}, w};
      end
      ALU_SRAW: begin
        w = $signed(a[31:0]) >>> b[4:0];
        y = {{32{w[31]}}, w};
      end
      ALU_PASSB: y = b;
      default:   y = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rv64_decoder.sv
`default_nettype none
// ============================================================================
// Module  : rv64_decoder
// Purpose : Combinational decode of one RV64I instruction for the OP, OP-IMM,
//           OP-32, OP-IMM-32 and LUI groups. Anything else is not legal.
// Ports   : instr   in  32  instruction word
//           rd/rs1/rs2 out 5 register specifiers
//           imm     out 64  sign-extended immediate (I-type or LUI form)
//           alu_op  out  4  ALU operation
//           use_imm out  1  operand B comes from imm instead of rs2
//           legal   out  1  instruction is supported
// Revision: 1.0 - initial release
// ============================================================================
module rv64_decoder
  import rv64_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [63:0] imm,
  output alu_op_e     alu_op,
  output logic        use_imm,
  output logic        legal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [5:0] funct6;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign funct6 = instr[31:26];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  always_comb begin
    imm     = {{52{instr[31]}}, instr[31:20]};
    alu_op  = ALU_ADD;
    use_imm = 1'b0;
    legal   = 1'b0;

    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          legal = 1'b1;
          case (funct3)
            F3_ADD_SUB: alu_op = ALU_ADD;
            F3_SLL:     alu_op = ALU_SLL;
            F3_SLT:     alu_op = ALU_SLT;
            F3_SLTU:    alu_op = ALU_SLTU;
            F3_XOR:     alu_op = ALU_XOR;
            F3_SRL_SRA: alu_op = ALU_SRL;
            F3_OR:      alu_op = ALU_OR;
            default:    alu_op = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            F3_ADD_SUB: begin alu_op = ALU_SUB; legal = 1'b1; end
            F3_SRL_SRA: begin alu_op = ALU_SRA; legal = 1'b1; end
            default:    legal = 1'b0;
          endcase
        end
      end

      OPC_OP_IMM: begin
        use_imm = 1'b1;
        case (funct3)
          F3_ADD_SUB: begin alu_op = ALU_ADD;  legal = 1'b1; end
          F3_SLT:     begin alu_op = ALU_SLT;  legal = 1'b1; end
          F3_SLTU:    begin alu_op = ALU_SLTU; legal = 1'b1; end
          F3_XOR:     begin alu_op = ALU_XOR;  legal = 1'b1; end
          F3_OR:      begin alu_op = ALU_OR;   legal = 1'b1; end
          F3_AND:     begin alu_op = ALU_AND;  legal = 1'b1; end
          F3_SLL: begin
            alu_op = ALU_SLL;
            legal  = (funct6 == F6_BASE);
          end
          default: begin
            // SRLI/SRAI: shamt occupies imm[5:0], funct6 selects the kind
            if (funct6 == F6_BASE) begin
              alu_op = ALU_SRL;
              legal  = 1'b1;
            end else if (funct6 == F6_ALT) begin
              alu_op = ALU_SRA;
              legal  = 1'b1;
            end
          end
        endcase
      end

      OPC_OP_32: begin
        case (funct3)
          F3_ADD_SUB: begin
            if (funct7 == F7_BASE) begin alu_op = ALU_ADDW; legal = 1'b1; end
            else if (funct7 == F7_ALT) begin alu_op = ALU_SUBW; legal = 1'b1; end
          end
          F3_SLL: begin
            alu_op = ALU_SLLW;
            legal  = (funct7 == F7_BASE);
          end
          F3_SRL_SRA: begin
            if (funct7 == F7_BASE) begin alu_op = ALU_SRLW; legal = 1'b1; end
            else if (funct7 == F7_ALT) begin alu_op = ALU_SRAW; legal = 1'b1; end
          end
          default: legal = 1'b0;
        endcase
      end

      OPC_OP_IMM_32: begin
        use_imm = 1'b1;
        // 32-bit immediate shifts check the full funct7, so instr[25]=1 is illegal
        case (funct3)
          F3_ADD_SUB: begin alu_op = ALU_ADDW; legal = 1'b1; end
          F3_SLL: begin
            alu_op = ALU_SLLW;
            legal  = (funct7 == F7_BASE);
          end
          F3_SRL_SRA: begin
            if (funct7 == F7_BASE) begin alu_op = ALU_SRLW; legal = 1'b1; end
            else if (funct7 == F7_ALT) begin alu_op = ALU_SRAW; legal = 1'b1; end
          end
          default: legal = 1'b0;
        endcase
      end

      OPC_LUI: begin
        imm     = {{32{instr[31]}}, instr[31:12], 12'b0};
        alu_op  = ALU_PASSB;
        use_imm = 1'b1;
        legal   = 1'b1;
      end

      default: legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rv64_regfile.sv
`default_nettype none
// ============================================================================
// Module  : rv64_regfile
// Purpose : NREGS x XLEN integer register file, two read ports, one write
//           port and a debug read port. Register 0 reads zero and is never
//           written. Reads are combinational and see the pre-edge contents.
// Ports   : clk, reset          clock / synchronous active-high reset
//           rs1_addr/rs1_data    read port A
//           rs2_addr/rs2_data    read port B
//           we/wr_addr/wr_data   write port
//           dbg_addr/dbg_data    debug read port
// Revision: 1.0 - initial release
// ============================================================================
module rv64_regfile #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule
`default_nettype wire

// File: rtl/rv64_int_datapath.sv
`default_nettype none
// ============================================================================
// Module  : rv64_int_datapath
// Purpose : Two-stage RV64I integer execute datapath. Edge N captures the
//           decoded instruction; during the next cycle the register file is
//           read and the ALU computes; edge N+1 retires the result and writes
//           the register file. Only XLEN=64 is supported.
// Ports   : clk    in  1  system clock
//           reset  in  1  synchronous active-high reset
//           bus    slave modport of rv64_int_datapath_if (issue, retire, debug)
// Revision: 1.0 - initial release
// ============================================================================
module rv64_int_datapath
  import rv64_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic                clk,
  input  logic                reset,
  rv64_int_datapath_if.slave  bus
);

  // Decode outputs
  logic [4:0]  id_rd, id_rs1, id_rs2;
  logic [63:0] id_imm;
  alu_op_e     id_op;
  logic        id_use_imm, id_legal;

  // Decode-stage registers
  logic        ex_valid;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic [63:0] ex_imm;
  alu_op_e     ex_op;
  logic        ex_use_imm, ex_legal;

  // Execute signals
  logic [XLEN-1:0] rs1_val, rs2_val, op_b, alu_y;
  logic            rf_we;

  // Retire registers
  logic            res_valid, res_illegal;
  logic [XLEN-1:0] res_data;
  logic [4:0]      res_rd;

  rv64_decoder u_decoder (
    .instr   (bus.instr),
    .rd      (id_rd),
    .rs1     (id_rs1),
    .rs2     (id_rs2),
    .imm     (id_imm),
    .alu_op  (id_op),
    .use_imm (id_use_imm),
    .legal   (id_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_rd      <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_imm     <= '0;
      ex_op      <= ALU_ADD;
      ex_use_imm <= 1'b0;
      ex_legal   <= 1'b0;
    end else begin
      ex_valid <= bus.instr_valid;
      if (bus.instr_valid) begin
        ex_rd      <= id_rd;
        ex_rs1     <= id_rs1;
        ex_rs2     <= id_rs2;
        ex_imm     <= id_imm;
        ex_op      <= id_op;
        ex_use_imm <= id_use_imm;
        ex_legal   <= id_legal;
      end
    end
  end

  // Writes land on the same edge the result retires, so the next issued
  // instruction already sees them and no forwarding is required.
  assign rf_we = ex_valid && ex_legal;

  rv64_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rs1_addr (ex_rs1),
    .rs2_addr (ex_rs2),
    .rs1_data (rs1_val),
    .rs2_data (rs2_val),
    .we       (rf_we),
    .wr_addr  (ex_rd),
    .wr_data  (alu_y),
    .dbg_addr (bus.dbg_addr),
    .dbg_data (bus.dbg_data)
  );

  // Immediate shifts take their shamt from imm[5:0], register shifts from rs2[5:0]
  assign op_b = ex_use_imm ? ex_imm : rs2_val;

  rv64_alu u_alu (
    .a  (rs1_val),
    .b  (op_b),
    .op (ex_op),
    .y  (alu_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid   <= 1'b0;
      res_illegal <= 1'b0;
      res_data    <= '0;
      res_rd      <= '0;
    end else begin
      res_valid <= ex_valid;
      // Bubbles leave the previous result, rd and illegal flag in place
      if (ex_valid) begin
        res_illegal <= !ex_legal;
        res_data    <= ex_legal ? alu_y : '0;
        res_rd      <= ex_rd;
      end
    end
  end

  assign bus.result_valid = res_valid;
  assign bus.result       = res_data;
  assign bus.result_rd    = res_rd;
  assign bus.illegal      = res_illegal;

endmodule
`default_nettype wire

// File: tb/tb_rv64_int_datapath.sv
`default_nettype none
// ============================================================================
// Module  : tb_rv64_int_datapath
// Purpose : Self-checking directed testbench for rv64_int_datapath.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_rv64_int_datapath;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  rv64_int_datapath_if bus ();

  rv64_int_datapath #(
    .XLEN  (64),
    .NREGS (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_dbg(input string tag, input logic [4:0] addr, input logic [63:0] exp);
    bus.dbg_addr = addr;
    #1;
    check(tag, bus.dbg_data, exp);
  endtask

  task automatic check_res(input string tag, input logic [63:0] r, input logic [4:0] rd,
                           input logic ill);
    check({tag, ".valid"},   {63'b0, bus.result_valid}, 64'd1);
    check({tag, ".result"},  bus.result, r);
    check({tag, ".rd"},      {59'b0, bus.result_rd}, {59'b0, rd});
    check({tag, ".illegal"}, {63'b0, bus.illegal}, {63'b0, ill});
  endtask

  // Issue one instruction isolated by bubbles and check its retire two edges later
  task automatic run_one(input string tag, input logic [31:0] ins, input logic [63:0] r,
                         input logic [4:0] rd, input logic ill);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr       = 32'h0;
    @(negedge clk);
    check_res(tag, r, rd, ill);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = 32'h0;
    bus.dbg_addr    = 5'd0;
    reset           = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst.valid",   {63'b0, bus.result_valid}, 64'd0);
    check("rst.illegal", {63'b0, bus.illegal}, 64'd0);
    check("rst.result",  bus.result, 64'd0);
    check("rst.rd",      {59'b0, bus.result_rd}, 64'd0);
    for (int i = 0; i < 32; i++) check_dbg("rst.reg", i[4:0], 64'd0);

    // Back-to-back issue, dependent reads one cycle behind their producers
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = 32'h00500093;  // ADDI x1,x0,5
    @(negedge clk);
    bus.instr       = 32'hFFD00113;  // ADDI x2,x0,-3
    @(negedge clk);
    check_res("b2b.addi1", 64'd5, 5'd1, 1'b0);
    bus.instr       = 32'h002081B3;  // ADD x3,x1,x2
    @(negedge clk);
    check_res("b2b.addi2", 64'hFFFFFFFFFFFFFFFD, 5'd2, 1'b0);
    bus.instr       = 32'h40208233;  // SUB x4,x1,x2
    @(negedge clk);
    check_res("b2b.add", 64'd2, 5'd3, 1'b0);
    bus.instr_valid = 1'b0;
    bus.instr       = 32'h0;
    @(negedge clk);
    check_res("b2b.sub", 64'd8, 5'd4, 1'b0);
    @(negedge clk);
    check("bubble.valid",  {63'b0, bus.result_valid}, 64'd0);
    check("bubble.result", bus.result, 64'd8);
    check("bubble.rd",     {59'b0, bus.result_rd}, 64'd4);
    check_dbg("dbg.x3", 5'd3, 64'd2);
    check_dbg("dbg.x4", 5'd4, 64'd8);

    // Shifts, LUI and W wrap
    run_one("srai",  32'h40115293, 64'hFFFFFFFFFFFFFFFE, 5'd5, 1'b0);
    run_one("lui",   32'h80000337, 64'hFFFFFFFF80000000, 5'd6, 1'b0);
    run_one("addiw", 32'hFFF3039B, 64'h000000007FFFFFFF, 5'd7, 1'b0);

    // Write to x0 is dropped but still retires
    run_one("addi_x0", 32'h00100013, 64'd1, 5'd0, 1'b0);
    check_dbg("dbg.x0", 5'd0, 64'd0);

    // Remaining R-type and W operations on x1=5, x2=-3
    run_one("slt",  32'h0020A433, 64'd0, 5'd8, 1'b0);
    run_one("sltu", 32'h0020B433, 64'd1, 5'd8, 1'b0);
    run_one("xor",  32'h0020C433, 64'hFFFFFFFFFFFFFFF8, 5'd8, 1'b0);
    run_one("or",   32'h0020E433, 64'hFFFFFFFFFFFFFFFD, 5'd8, 1'b0);
    run_one("and",  32'h0020F433, 64'd5, 5'd8, 1'b0);
    run_one("sll",  32'h00209433, 64'hA000000000000000, 5'd8, 1'b0);
    run_one("srl",  32'h00115433, 64'h07FFFFFFFFFFFFFF, 5'd8, 1'b0);
    run_one("sra",  32'h40115433, 64'hFFFFFFFFFFFFFFFF, 5'd8, 1'b0);
    run_one("subw", 32'h4020843B, 64'd8, 5'd8, 1'b0);
    run_one("sllw", 32'h0020943B, 64'hFFFFFFFFA0000000, 5'd8, 1'b0);
    run_one("srlw", 32'h0011543B, 64'h0000000007FFFFFF, 5'd8, 1'b0);
    run_one("sraw", 32'h4011543B, 64'hFFFFFFFFFFFFFFFF, 5'd8, 1'b0);
    run_one("slli63", 32'h03F09413, 64'h8000000000000000, 5'd8, 1'b0);

    // Illegal encodings: result 0, no write to x8
    run_one("ill.zero",  32'h00000000, 64'd0, 5'd0, 1'b1);
    run_one("ill.slli",  32'h43F09413, 64'd0, 5'd8, 1'b1);
    run_one("ill.mul",   32'h02208433, 64'd0, 5'd8, 1'b1);
    run_one("ill.slliw", 32'h0200941B, 64'd0, 5'd8, 1'b1);
    run_one("ill.beq",   32'h00208463, 64'd0, 5'd8, 1'b1);
    check_dbg("dbg.x8", 5'd8, 64'h8000000000000000);
    check_dbg("dbg.x1", 5'd1, 64'd5);
    check_dbg("dbg.x2", 5'd2, 64'hFFFFFFFFFFFFFFFD);
    check_dbg("dbg.x5", 5'd5, 64'hFFFFFFFFFFFFFFFE);
    check_dbg("dbg.x6", 5'd6, 64'hFFFFFFFF80000000);
    check_dbg("dbg.x7", 5'd7, 64'h000000007FFFFFFF);

    // Reset while ADDI x9,x0,7 sits in the decode stage
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = 32'h00700493;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr       = 32'h0;
    reset           = 1'b1;
    @(negedge clk);
    check("midrst.valid",  {63'b0, bus.result_valid}, 64'd0);
    check("midrst.result", bus.result, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst.valid2", {63'b0, bus.result_valid}, 64'd0);
    for (int i = 0; i < 32; i++) check_dbg("midrst.reg", i[4:0], 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
